// File: rtl/vga_rx_monitor.sv
// VGA receive monitor: recovers raster position from Hs/Vs, checks timing, locks onto
// the stream, reports active pixels and captures one probed pixel colour per frame.
module vga_rx_monitor #(
    parameter int unsigned H_SYNC_CYC     = 96,
    parameter int unsigned H_BACK_PORCH   = 48,
    parameter int unsigned H_ACTIVE_VIDEO = 640,
    parameter int unsigned H_LINE         = 800,
    parameter int unsigned V_SYNC_CYC     = 2,
    parameter int unsigned V_BACK_PORCH   = 33,
    parameter int unsigned V_ACTIVE_VIDEO = 480,
    parameter int unsigned V_LINE         = 525
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vgaHs,
    input  logic       vgaVs,
    input  logic [2:0] vgaR,
    input  logic [2:0] vgaG,
    input  logic [2:0] vgaB,
    output logic       pix_valid,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic [8:0] pix_rgb,
    output logic       frame_start,
    output logic       locked,
    output logic       h_err,
    output logic       v_err,
    output logic [7:0] err_cnt,
    input  logic [9:0] probe_x,
    input  logic [9:0] probe_y,
    output logic [8:0] probe_rgb,
    output logic       probe_done
);

    typedef enum logic [1:0] {StUnlocked, StAcquire, StLocked} state_e;

    localparam logic [9:0] L_H_START = 10'(H_SYNC_CYC + H_BACK_PORCH);
    localparam logic [9:0] L_H_END   = 10'(H_SYNC_CYC + H_BACK_PORCH + H_ACTIVE_VIDEO);
    localparam logic [9:0] L_V_START = 10'(V_SYNC_CYC + V_BACK_PORCH);
    localparam logic [9:0] L_V_END   = 10'(V_SYNC_CYC + V_BACK_PORCH + V_ACTIVE_VIDEO);
    localparam logic [9:0] L_H_LAST  = 10'(H_LINE - 1);
    localparam logic [9:0] L_V_LAST  = 10'(V_LINE - 1);
    localparam logic [9:0] L_H_SYNC  = 10'(H_SYNC_CYC);
    localparam logic [9:0] L_V_SYNC  = 10'(V_SYNC_CYC);
    localparam logic [9:0] L_H_ACT   = 10'(H_ACTIVE_VIDEO);
    localparam logic [9:0] L_V_ACT   = 10'(V_ACTIVE_VIDEO);

    logic       r_s1_hs, r_s1_vs, r_s2_hs, r_s2_vs;
    logic [8:0] r_s1_rgb;
    logic [9:0] r_hcnt, r_vcnt;
    logic       r_vs_pend, r_hs_seen, r_acq_err, r_probe_armed;
    logic [9:0] r_probe_x, r_probe_y;
    state_e     r_state, w_state_nxt;
    logic       w_acq_err_nxt;

    logic       r_pix_valid, r_frame_start, r_h_err, r_v_err, r_probe_done;
    logic [9:0] r_pix_x, r_pix_y;
    logic [8:0] r_pix_rgb, r_probe_rgb;
    logic [7:0] r_err_cnt;

    logic       w_hs_fall, w_hs_rise, w_vs_fall, w_vs_rise, w_vreset;
    logic       w_h_err, w_v_err, w_err, w_active, w_valid, w_probe_hit;
    logic [9:0] w_hcnt_nxt, w_vcnt_nxt;

    assign w_hs_fall = !r_s1_hs && r_s2_hs;
    assign w_hs_rise = r_s1_hs && !r_s2_hs;
    assign w_vs_fall = !r_s1_vs && r_s2_vs;
    assign w_vs_rise = r_s1_vs && !r_s2_vs;
    assign w_vreset  = w_hs_fall && (r_vs_pend || w_vs_fall);

    assign w_hcnt_nxt = w_hs_fall ? 10'd0 :
                        (r_hcnt == 10'h3FF) ? r_hcnt : r_hcnt + 10'd1;
    assign w_vcnt_nxt = w_vreset ? 10'd0 :
                        (w_hs_fall && r_vcnt != 10'h3FF) ? r_vcnt + 10'd1 : r_vcnt;

    // Nothing is trusted until one full line has been bracketed by Hs falls.
    assign w_h_err = r_hs_seen && ((w_hs_fall && r_hcnt != L_H_LAST) ||
                                   (w_hs_rise && w_hcnt_nxt != L_H_SYNC));
    assign w_v_err = r_hs_seen && ((w_vreset && r_vcnt != L_V_LAST) ||
                                   (w_vs_rise && w_vcnt_nxt != L_V_SYNC));
    assign w_err   = w_h_err || w_v_err;

    assign w_active = (w_hcnt_nxt >= L_H_START) && (w_hcnt_nxt < L_H_END) &&
                      (w_vcnt_nxt >= L_V_START) && (w_vcnt_nxt < L_V_END);
    assign w_valid  = (w_state_nxt == StLocked) && w_active;

    assign w_probe_hit = r_pix_valid && r_probe_armed && (r_pix_x == r_probe_x) &&
                         (r_pix_y == r_probe_y) && (r_probe_x < L_H_ACT) && (r_probe_y < L_V_ACT);

    always_comb begin
        w_state_nxt   = r_state;
        w_acq_err_nxt = r_acq_err;
        unique case (r_state)
            StUnlocked: begin
                w_acq_err_nxt = 1'b0;
                if (w_vreset) w_state_nxt = StAcquire;
            end
            StAcquire: begin
                if (w_vreset) begin
                    w_acq_err_nxt = 1'b0;
                    if (!r_acq_err && !w_err) w_state_nxt = StLocked;
                end else if (w_err) begin
                    w_acq_err_nxt = 1'b1;
                end
            end
            StLocked: begin
                if (w_err) w_state_nxt = StUnlocked;
            end
            default: w_state_nxt = StUnlocked;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= StUnlocked;
            r_acq_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_acq_err <= w_acq_err_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_hs       <= 1'b1;
            r_s1_vs       <= 1'b1;
            r_s2_hs       <= 1'b1;
            r_s2_vs       <= 1'b1;
            r_s1_rgb      <= '0;
            r_hcnt        <= '0;
            r_vcnt        <= '0;
            r_vs_pend     <= 1'b1;
            r_hs_seen     <= 1'b0;
            r_probe_armed <= 1'b0;
            r_probe_x     <= '0;
            r_probe_y     <= '0;
            r_pix_valid   <= 1'b0;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_pix_rgb     <= '0;
            r_frame_start <= 1'b0;
            r_h_err       <= 1'b0;
            r_v_err       <= 1'b0;
            r_err_cnt     <= '0;
            r_probe_rgb   <= '0;
            r_probe_done  <= 1'b0;
        end else begin
            r_s1_hs  <= vgaHs;
            r_s1_vs  <= vgaVs;
            r_s1_rgb <= {vgaR, vgaG, vgaB};
            r_s2_hs  <= r_s1_hs;
            r_s2_vs  <= r_s1_vs;
            r_hcnt   <= w_hcnt_nxt;
            r_vcnt   <= w_vcnt_nxt;
            if (w_vreset)       r_vs_pend <= 1'b0;
            else if (w_vs_fall) r_vs_pend <= 1'b1;
            if (w_hs_fall) r_hs_seen <= 1'b1;

            r_pix_valid   <= w_valid;
            r_pix_x       <= w_valid ? w_hcnt_nxt - L_H_START : 10'd0;
            r_pix_y       <= w_valid ? w_vcnt_nxt - L_V_START : 10'd0;
            r_pix_rgb     <= w_valid ? r_s1_rgb : 9'd0;
            r_frame_start <= w_vreset;
            r_h_err       <= w_h_err;
            r_v_err       <= w_v_err;
            if (r_state == StLocked && w_err && r_err_cnt != 8'hFF) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end

            // Probe coordinates only change on a frame boundary so a capture never tears.
            if (w_vreset) begin
                r_probe_x     <= probe_x;
                r_probe_y     <= probe_y;
                r_probe_armed <= 1'b1;
            end else if (w_probe_hit) begin
                r_probe_armed <= 1'b0;
            end
            r_probe_done <= w_probe_hit;
            if (w_probe_hit) r_probe_rgb <= r_pix_rgb;
        end
    end

    assign locked      = (r_state == StLocked);
    assign pix_valid   = r_pix_valid;
    assign pix_x       = r_pix_x;
    assign pix_y       = r_pix_y;
    assign pix_rgb     = r_pix_rgb;
    assign frame_start = r_frame_start;
    assign h_err       = r_h_err;
    assign v_err       = r_v_err;
    assign err_cnt     = r_err_cnt;
    assign probe_rgb   = r_probe_rgb;
    assign probe_done  = r_probe_done;

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed bench for vga_rx_monitor on a reduced raster (48x32 total, 32x24 active).
module tb_vga_rx_monitor;

    localparam int HS = 8, HBP = 4, HA = 32, HL = 48;
    localparam int VS = 2, VBP = 3, VA = 24, VL = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vgaHs, vgaVs;
    logic [2:0] vgaR, vgaG, vgaB;
    logic       pix_valid, frame_start, locked, h_err, v_err, probe_done;
    logic [9:0] pix_x, pix_y, probe_x, probe_y;
    logic [8:0] pix_rgb, probe_rgb;
    logic [7:0] err_cnt;

    int n_chk = 0, n_err = 0;
    int n_herr = 0, n_verr = 0, n_pd = 0;
    int g_h = 0, g_v = 0, frame_len = VL, vs_lines = VS, short_v = -1;
    int drv_h = -1, drv_v = -1, obs_h = -1, obs_v = -1;
    bit gen_on = 1'b0;

    vga_rx_monitor #(
        .H_SYNC_CYC(HS), .H_BACK_PORCH(HBP), .H_ACTIVE_VIDEO(HA), .H_LINE(HL),
        .V_SYNC_CYC(VS), .V_BACK_PORCH(VBP), .V_ACTIVE_VIDEO(VA), .V_LINE(VL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .vgaHs(vgaHs), .vgaVs(vgaVs),
        .vgaR(vgaR), .vgaG(vgaG), .vgaB(vgaB),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
        .frame_start(frame_start), .locked(locked), .h_err(h_err), .v_err(v_err),
        .err_cnt(err_cnt), .probe_x(probe_x), .probe_y(probe_y),
        .probe_rgb(probe_rgb), .probe_done(probe_done)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] pat(int h, int v);
        if (h == 12 && v == 5) return 9'h1C7;   // pixel (0,0)
        if (h == 22 && v == 25) return 9'h0A5;  // pixel (10,20)
        return 9'(h * 3 + v * 5);
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one pixel, clock once; outputs then reflect the pixel driven one step earlier.
    task automatic step();
        logic [8:0] c;
        int len;
        obs_h = drv_h;
        obs_v = drv_v;
        if (gen_on) begin
            c = pat(g_h, g_v);
            vgaHs = (g_h >= HS);
            vgaVs = (g_v >= vs_lines);
            {vgaR, vgaG, vgaB} = c;
            drv_h = g_h;
            drv_v = g_v;
            len = (g_v == short_v) ? HL - 1 : HL;
            g_h++;
            if (g_h == len) begin
                g_h = 0;
                if (g_v == short_v) short_v = -1;
                g_v++;
                if (g_v >= frame_len) g_v = 0;
            end
        end else begin
            vgaHs = 1'b1;
            vgaVs = 1'b1;
            {vgaR, vgaG, vgaB} = 9'd0;
            drv_h = -1;
            drv_v = -1;
        end
        @(posedge clk);
        #1;
        if (h_err) n_herr++;
        if (v_err) n_verr++;
        if (probe_done) n_pd++;
    endtask

    task automatic wait_fs(string tag);
        int n = 0;
        do begin step(); n++; end while (!frame_start && n < 3000);
        chk(tag, frame_start, 1);
    endtask

    task automatic run_to(string tag, int h, int v);
        int n = 0;
        do begin step(); n++; end while (!(obs_h == h && obs_v == v) && n < 3000);
        chk(tag, (obs_h == h && obs_v == v), 1);
    endtask

    task automatic wait_err(string tag, bit vert);
        int n = 0;
        do begin step(); n++; end while (!(vert ? v_err : h_err) && n < 3000);
        chk(tag, vert ? v_err : h_err, 1);
    endtask

    initial begin
        rst_n   = 1'b0;
        probe_x = 10'd700;
        probe_y = 10'd0;
        repeat (3) step();
        chk("rst_valid", pix_valid, 0);
        chk("rst_locked", locked, 0);
        chk("rst_outs", {pix_x, pix_y, pix_rgb, frame_start, h_err, v_err, probe_done}, 0);
        chk("rst_errcnt", err_cnt, 0);
        chk("rst_probe_rgb", probe_rgb, 0);

        // Nominal acquisition from the top of a frame
        rst_n  = 1'b1;
        gen_on = 1'b1;
        wait_fs("fs1");
        chk("fs1_pos", (obs_h == 0 && obs_v == 0), 1);
        chk("fs1_locked", locked, 0);
        wait_fs("fs2");
        chk("fs2_locked", locked, 1);
        chk("fs2_herr", n_herr, 0);
        chk("fs2_verr", n_verr, 0);
        chk("fs2_errcnt", err_cnt, 0);
        probe_x = 10'd10;
        probe_y = 10'd20;

        // Active-area boundaries
        run_to("r_12_4", 12, 4);
        chk("row4_valid", pix_valid, 0);
        run_to("r_11_5", 11, 5);
        chk("col11_valid", pix_valid, 0);
        chk("col11_x", pix_x, 0);
        step();
        chk("first_valid", pix_valid, 1);
        chk("first_xy", {pix_x, pix_y}, 0);
        chk("first_rgb", pix_rgb, 9'h1C7);
        run_to("r_43_28", 43, 28);
        chk("last_valid", pix_valid, 1);
        chk("last_x", pix_x, 31);
        chk("last_y", pix_y, 23);
        chk("last_rgb", pix_rgb, pat(43, 28));
        step();
        chk("after_last_valid", pix_valid, 0);
        chk("after_last_rgb", pix_rgb, 0);
        run_to("r_12_29", 12, 29);
        chk("row29_valid", pix_valid, 0);

        // Probe: new coordinate only effective from the following frame
        wait_fs("fs3");
        chk("probe_none_f2", n_pd, 0);
        run_to("r_0_30", 0, 30);
        chk("probe_once_f3", n_pd, 1);
        chk("probe_rgb_f3", probe_rgb, 9'h0A5);
        probe_x = 10'd700;
        wait_fs("fs4");
        wait_fs("fs5");
        chk("probe_oor_none", n_pd, 1);
        chk("probe_rgb_hold", probe_rgb, 9'h0A5);

        // Short line while locked
        short_v = 10;
        wait_err("short_herr", 1'b0);
        chk("short_locked", locked, 0);
        chk("short_errcnt", err_cnt, 1);
        wait_fs("fs6");
        chk("fs6_locked", locked, 0);
        wait_fs("fs7");
        chk("fs7_relocked", locked, 1);
        chk("fs7_herr_total", n_herr, 1);
        chk("fs7_verr_total", n_verr, 0);

        // Frame one line short
        frame_len = VL - 1;
        wait_err("short_frame_verr", 1'b1);
        frame_len = VL;
        chk("short_frame_fs", frame_start, 1);
        chk("short_frame_locked", locked, 0);
        chk("short_frame_errcnt", err_cnt, 2);
        wait_fs("fs9");
        wait_fs("fs10");
        chk("fs10_locked", locked, 1);

        // Vs held low for one extra line
        vs_lines = VS + 1;
        wait_err("long_vs_verr", 1'b1);
        vs_lines = VS;
        chk("long_vs_pos", (obs_h == 0 && obs_v == 3), 1);
        chk("long_vs_locked", locked, 0);
        chk("long_vs_errcnt", err_cnt, 3);
        wait_fs("fs11");
        wait_fs("fs12");
        chk("fs12_locked", locked, 1);

        // One-cycle reset in the middle of an active line
        run_to("r_20_10", 20, 10);
        chk("pre_rst_valid", pix_valid, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_outs", {pix_valid, pix_x, pix_y, pix_rgb, frame_start, probe_done}, 0);
        chk("mid_rst_locked", locked, 0);
        chk("mid_rst_errcnt", err_cnt, 0);
        chk("mid_rst_probe_rgb", probe_rgb, 0);
        wait_fs("re_fs1");
        chk("re_fs1_locked", locked, 0);
        wait_fs("re_fs2");
        chk("re_fs2_locked", locked, 0);
        wait_fs("re_fs3");
        chk("re_fs3_locked", locked, 1);
        chk("re_errcnt", err_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
